// File: rtl/multicycle_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_mem_port
// Purpose  : Shared fetch/load/store memory port. Splits a core word into
//            narrow memory beats and tolerates memory wait states.
// Revision : 1.0
// ============================================================================
module multicycle_mem_port #(
  parameter int ADDRESS_SIZE = 20,
  parameter int WORD_SIZE    = 64,
  parameter int MEM_WIDTH    = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDRESS_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0]    req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WORD_SIZE-1:0]    rsp_rdata,
  output logic                    rsp_error,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0]    mem_wdata,
  input  logic [MEM_WIDTH-1:0]    mem_rdata,
  input  logic                    mem_ack
);

  localparam int BEATS  = WORD_SIZE / MEM_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS - 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]    rdata_q, rdata_d;
  logic                    write_q, write_d;
  logic                    error_q, error_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    write_d = write_q;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          rdata_d = '0;
          beat_d  = '0;
          wait_d  = '0;
          error_d = 1'b0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          if (!write_q) begin
            rdata_d[beat_q*MEM_WIDTH +: MEM_WIDTH] = mem_rdata;
          end
          wait_d = '0;
          if (beat_q == LAST_BEAT) begin
            state_d = RESP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else begin
          wait_d = wait_q + 1'b1;
          // A zero TIMEOUT lets the counter wrap harmlessly and never aborts
          if ((TIMEOUT != 0) && (wait_d == TIMEOUT_CNT)) begin
            error_d = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = (state_q == ACCESS) && write_q;
  assign mem_addr  = (state_q == ACCESS) ? (addr_q + ADDRESS_SIZE'(beat_q)) : '0;
  assign mem_wdata = (state_q == ACCESS) ? wdata_q[beat_q*MEM_WIDTH +: MEM_WIDTH] : '0;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
  assign rsp_error = (state_q == RESP) && error_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_mem_port
// Purpose  : Randomised self-checking bench with a word-level memory model.
// Revision : 1.0
// ============================================================================
module tb_multicycle_mem_port;

  localparam int AW    = 20;
  localparam int WW    = 64;
  localparam int MW    = 16;
  localparam int TO    = 8;
  localparam int BEATS = WW / MW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [WW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [WW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_wdata;
  logic [MW-1:0] mem_rdata;
  logic          mem_ack;

  multicycle_mem_port #(
    .ADDRESS_SIZE(AW),
    .WORD_SIZE   (WW),
    .MEM_WIDTH   (MW),
    .TIMEOUT     (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word-level memory contents; only the stimulus process writes it
  logic [MW-1:0] mem_model [logic [AW-1:0]];

  function automatic logic [MW-1:0] mem_rd(input logic [AW-1:0] a);
    logic [MW-1:0] h;
    if (mem_model.exists(a)) return mem_model[a];
    h = a[MW-1:0] ^ 16'h5A5A;
    return h;
  endfunction

  typedef struct packed {
    logic [AW-1:0] a;
    logic          we;
    logic [MW-1:0] d;
  } beat_t;

  beat_t beat_log[$];
  int    mem_wait  = 0;
  int    ack_limit = BEATS;
  int    wcnt      = 0;
  int    acks      = 0;

  // Memory responder: decides ack on the falling edge, logs every acked beat
  always @(negedge clk) begin
    beat_t b;
    if (mem_en) begin
      if (wcnt >= mem_wait && acks < ack_limit) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_rd(mem_addr);
        b         = {mem_addr, mem_we, mem_wdata};
        beat_log.push_back(b);
        wcnt      = 0;
        acks++;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = MW'($urandom);
        wcnt++;
      end
    end else begin
      mem_ack   = 1'($urandom);
      mem_rdata = MW'($urandom);
      wcnt      = 0;
      acks      = 0;
    end
  end

  task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [WW-1:0] wd,
                        input int wait_n, input int limit, input int hold, input logic overlap);
    logic [WW-1:0] exp_rd;
    logic          exp_err;
    logic [AW-1:0] a;
    int            n_ack;
    int            exp_lat;
    int            cyc;
    int            base;
    n_ack   = (limit < BEATS) ? limit : BEATS;
    exp_err = (n_ack < BEATS);
    exp_rd  = '0;
    for (int i = 0; i < n_ack; i++) begin
      a = addr + AW'(i);
      if (!wr) exp_rd = exp_rd | (WW'(mem_rd(a)) << (MW * i));
    end
    exp_lat = n_ack * (wait_n + 1) + (exp_err ? TO : 0);

    @(negedge clk);
    mem_wait  = wait_n;
    ack_limit = limit;
    base      = beat_log.size();
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = AW'($urandom);
    req_wdata = {$urandom, $urandom};
    chk("busy_after_accept", {req_ready, mem_en}, 2'b01);

    cyc = 0;
    while (!rsp_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!rsp_valid) begin
      chk("rsp_never_valid", 0, 1);
      return;
    end
    chk("latency", cyc, exp_lat);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_error", rsp_error, exp_err);
    chk("req_ready_resp", {req_ready, mem_en}, 2'b00);

    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("rsp_hold_ctrl", {rsp_valid, rsp_error, req_ready, mem_en}, {1'b1, exp_err, 2'b00});
      chk("rsp_hold_rdata", rsp_rdata, exp_rd);
    end

    rsp_ready = 1'b1;
    if (overlap) begin
      req_valid = 1'b1;
      req_addr  = AW'($urandom);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("after_handshake", {rsp_valid, req_ready, mem_en}, 3'b010);

    chk("beat_count", beat_log.size() - base, n_ack);
    for (int i = 0; i < n_ack && base + i < beat_log.size(); i++) begin
      a = addr + AW'(i);
      chk("beat_addr", beat_log[base+i].a, a);
      chk("beat_we", beat_log[base+i].we, wr);
      chk("beat_wdata", beat_log[base+i].d, wd[MW*i +: MW]);
    end
    // Acked store beats land in memory even if the word later timed out
    if (wr) begin
      for (int i = 0; i < n_ack; i++) begin
        a = addr + AW'(i);
        mem_model[a] = wd[MW*i +: MW];
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lim;
    logic [AW-1:0] ra;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {req_ready, rsp_valid, rsp_error, mem_en, mem_we}, 5'b10000);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    mem_model[20'h00010] = 16'h1111;
    mem_model[20'h00011] = 16'h2222;
    mem_model[20'h00012] = 16'h3333;
    mem_model[20'h00013] = 16'h4444;
    do_txn(1'b0, 20'h00010, 64'h0, 0, BEATS, 0, 1'b0);
    do_txn(1'b1, 20'h00020, 64'hDEADBEEFCAFEF00D, 0, BEATS, 0, 1'b0);
    do_txn(1'b0, 20'hFFFFE, 64'h0123456789ABCDEF, 0, BEATS, 1, 1'b0);

    mem_model[20'h00030] = 16'hAAAA;
    mem_model[20'h00031] = 16'hBBBB;
    do_txn(1'b0, 20'h00030, 64'h0, 0, 2, 0, 1'b0);
    do_txn(1'b0, 20'h00040, 64'h0, 0, BEATS, 0, 1'b0);

    do_txn(1'b0, 20'h00020, 64'h0, 3, BEATS, 5, 1'b1);

    // Asynchronous reset in the middle of beat 2 of a load
    @(negedge clk);
    mem_wait  = 0;
    ack_limit = BEATS;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 20'h00050;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_reset_beat2", {mem_en, mem_addr}, {1'b1, 20'h00052});
    rst_n = 1'b0;
    #1;
    chk("async_reset", {mem_en, rsp_valid, req_ready}, 3'b001);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_idle", {req_ready, rsp_valid, mem_en}, 3'b100);
    do_txn(1'b0, 20'h00050, 64'h0, 1, BEATS, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      lim = ($urandom_range(0, 4) == 0) ? $urandom_range(0, BEATS - 1) : BEATS;
      ra  = ($urandom_range(0, 3) == 0) ? AW'(20'hFFFFC + $urandom_range(0, 3)) : AW'($urandom_range(0, 63));
      do_txn(1'($urandom), ra, {$urandom, $urandom}, $urandom_range(0, 3), lim,
             $urandom_range(0, 3), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
